fft_r2_sequencer: RTL

In-place radix-2 DIT FFT controller that time-shares one combinational `butterfly_2` instance across all butterflies of a POINTS-point transform. It generates the read addresses for the operand pair, the twiddle-ROM index, and the delayed write-back addresses for the data RAM. It sits between the data RAM/twiddle ROM and the butterfly, and is started by the host once bit-reversed input samples are loaded.

---
 rtl/fft_pkg.sv | 9 +
 rtl/fft_addr_gen.sv | 24 ++
 rtl/fft_r2_sequencer.sv | 79 +++++++
 3 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: shared FSM encoding and default geometry for the radix-2 FFT sequencer.
package fft_pkg;
  localparam int POINTS_DEF = 8;
  localparam int LOG2P_DEF  = 3;
  localparam int HALF_PTS   = POINTS_DEF / 2;
  localparam int TW_W       = LOG2P_DEF - 1;
  localparam int STG_W      = 4;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;
endpackage

// File: rtl/fft_addr_gen.sv
// fft_addr_gen: maps (stage, butterfly index) to operand pair addresses and twiddle index.
module fft_addr_gen
  import fft_pkg::*;
#(
  parameter int LOG2P = LOG2P_DEF
) (
  input  logic [STG_W-1:0] i_stage,
  input  logic [LOG2P-2:0] i_k,
  output logic [LOG2P-1:0] o_a,
  output logic [LOG2P-1:0] o_b,
  output logic [LOG2P-2:0] o_m
);
  logic [LOG2P-1:0] w_k, w_half, w_j, w_g, w_a;
  always_comb begin
    w_k    = {1'b0, i_k};
    w_half = LOG2P'(1) << i_stage;
    w_j    = w_k & (w_half - LOG2P'(1));
    w_g    = w_k >> i_stage;
    w_a    = (w_g << (i_stage + STG_W'(1))) | w_j;
    o_a    = w_a;
    o_b    = w_a + w_half;
    o_m    = (LOG2P-1)'(w_j << (STG_W'(LOG2P - 1) - i_stage));
  end
endmodule

// File: rtl/fft_r2_sequencer.sv
// fft_r2_sequencer: in-place radix-2 DIT FFT controller sharing one butterfly;
// issues one butterfly per cycle with a one-cycle bubble between stages.
module fft_r2_sequencer
  import fft_pkg::*;
#(
  parameter int POINTS = POINTS_DEF,
  parameter int LOG2P  = LOG2P_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [STG_W-1:0] stage,
  output logic             rd_en,
  output logic [LOG2P-1:0] rd_addr_a,
  output logic [LOG2P-1:0] rd_addr_b,
  output logic [LOG2P-2:0] tw_addr,
  output logic             wr_en,
  output logic [LOG2P-1:0] wr_addr_a,
  output logic [LOG2P-1:0] wr_addr_b
);
  localparam int HP = POINTS / 2;
  state_t           r_state, w_next;
  logic [STG_W-1:0] r_stage;
  logic [LOG2P-2:0] r_k, w_m;
  logic [LOG2P-1:0] w_a, w_b, r_wr_a, r_wr_b;
  logic             w_last_k, w_last_stage, r_wr_en;

  fft_addr_gen #(.LOG2P(LOG2P)) u_addr (
    .i_stage(r_stage),
    .i_k    (r_k),
    .o_a    (w_a),
    .o_b    (w_b),
    .o_m    (w_m)
  );

  always_comb begin
    w_last_k     = r_k == (LOG2P-1)'(HP - 1);
    w_last_stage = r_stage == STG_W'(LOG2P - 1);
    w_next       = r_state;
    case (r_state)
      S_IDLE:  w_next = start ? S_RUN : S_IDLE;
      S_RUN:   w_next = w_last_k ? S_DRAIN : S_RUN;
      S_DRAIN: w_next = w_last_stage ? S_IDLE : S_RUN;
      default: w_next = S_IDLE;
    endcase
  end

  // The write-back registers simply trail the read side by one cycle (RAM read latency).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_stage <= '0;
      r_k     <= '0;
      r_wr_en <= 1'b0;
      r_wr_a  <= '0;
      r_wr_b  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_RUN) r_k <= w_last_k ? '0 : r_k + 1'b1;
      if (r_state == S_DRAIN) r_stage <= w_last_stage ? '0 : r_stage + 1'b1;
      r_wr_en <= rd_en;
      r_wr_a  <= rd_addr_a;
      r_wr_b  <= rd_addr_b;
    end
  end

  assign busy      = r_state != S_IDLE;
  assign rd_en     = r_state == S_RUN;
  assign done      = (r_state == S_DRAIN) && w_last_stage;
  assign stage     = r_stage;
  assign rd_addr_a = rd_en ? w_a : '0;
  assign rd_addr_b = rd_en ? w_b : '0;
  assign tw_addr   = rd_en ? w_m : '0;
  assign wr_en     = r_wr_en;
  assign wr_addr_a = r_wr_a;
  assign wr_addr_b = r_wr_b;
endmodule
